dot_prod_stream: RTL and testbench
==================================

# dot_prod_stream

Parametrised, pipelined dot-product engine: computes init_acc + Σ a[(init_i+k) mod DEPTH]·b[(init_i+k) mod DEPTH] for k = 0..init_len-1 over two external synchronous-read arrays. It is the generalised successor of the fixed 1000-element scheduled dot-product core. It adds:
- runtime length and start index with index wrap-around;
- signed/unsigned and wrap/saturate modes;
- one element issued per cycle.

It sits between a controller that pulses r_enable and the array memories.

## Interface
Parameters:
- DATA_W, 32, element width of a and b.
- ACC_W, 64, accumulator/result width; must be ≥ 2·DATA_W.
- DEPTH, 1000, array entries; indices wrap at DEPTH.
- ADDR_W, 10, address width; 2^ADDR_W ≥ DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- r_enable  in  1  start strobe; samples all init_* and mode_* inputs.
- init_i  in  ADDR_W  start index, < DEPTH.
- init_len  in  ADDR_W+1  element count, 0..DEPTH.
- init_acc  in  ACC_W  initial accumulator value.
- mode_signed  in  1  1: operands and accumulator are two's complement; 0: unsigned.
- mode_sat  in  1  1: saturating accumulate; 0: modulo 2^ACC_W.
- arrRen  out  1  array read enable.
- arrRaddr_a, arrRaddr_b  out  ADDR_W  array read addresses (always equal).
- arrRdata_a, arrRdata_b  in  DATA_W  read data, valid the cycle after arrRen.
- busy  out  1  operation in progress.
- w_enable  out  1  result valid; held until next r_enable or rst.
- result  out  ACC_W  final accumulator.
- overflow  out  1  sticky; set if any accumulate overflowed in the current mode.

## Operation
State machine:
- IDLE → ISSUE on r_enable with init_len > 0.
- IDLE → DONE on r_enable with init_len = 0; result = init_acc.
- ISSUE → DRAIN after the issue of element init_len-1.
- DRAIN → DONE when the last product has been accumulated.
- DONE → ISSUE or DONE on r_enable, following the same rules as from IDLE.

Pipeline:
- Stage 0 (issue): arrRen=1; address idx; idx increments and wraps DEPTH-1 → 0.
- Stage 1: the product register captures arrRdata_a·arrRdata_b. Operands are sign- or zero-extended per mode; the result is 2·DATA_W wide.
- Stage 2: acc ← acc + extend(product) to ACC_W.

Arithmetic:
- Overflow (signed): operands of equal sign, result sign differs.
- Overflow (unsigned): carry out.
- With mode_sat=1, an overflowed sum clamps to the signed max/min (signed mode) or to 2^ACC_W-1 (unsigned mode). Later terms continue from the clamped value.
- overflow is set on any overflow event, in both wrap and saturate modes.

Start and abort:
- r_enable in any state, including mid-run, aborts the current operation.
- On abort, all in-flight pipeline stages are discarded: no stale product is accumulated.
- r_enable reloads all operands and the accumulator, clears w_enable and overflow, and restarts.

## Timing
- Let E0 be the edge at which r_enable is sampled.
- Element k is issued in the cycle after edge E0+k.
- Its data arrives after E0+k+1 and its product is registered at E0+k+2.
- Its product is accumulated at E0+k+3.
- For init_len = L > 0: w_enable and result become valid after edge E0+L+2, and busy falls on the same edge.
- For L = 0: w_enable is valid after E0+1 and busy never asserts.
- busy is 1 from after E0 until w_enable rises.
- arrRen is high for exactly L cycles.
- Reset values: state IDLE, busy=0, w_enable=0, result=0, overflow=0, arrRen=0, addresses 0, acc 0. Reset takes effect immediately (asynchronously), including mid-run.

## Test plan
Unless stated otherwise, bench arrays hold a[i]=b[i]=i, with DEPTH=1000, signed mode and wrap mode.
1. Full run: init_i=0, L=1000, init_acc=0 → result=332833500, w_enable after E0+1002, arrRen high for 1000 cycles.
2. Wrap-around: init_i=998, L=4, init_acc=6 → addresses 998, 999, 0, 1; result=1994012; w_enable after E0+6.
3. Zero length: L=0, init_acc=42 → result=42, w_enable after E0+1, arrRen and busy never assert.
4. Saturation: arrays all 0x80000000, init_acc=0x4000000000000000, L=2.
   - mode_sat=1 → result=0x7FFFFFFFFFFFFFFF.
   - mode_sat=0 → result=0xC000000000000000.
   - overflow=1 in both cases.
5. Abort: start L=1000; pulse r_enable after 10 issues with init_i=2, L=3, init_acc=0 → result=29 after E0'+5, overflow=0.
6. Reset mid-run: assert rst during ISSUE → all outputs drop to reset values without waiting for a clock edge. A subsequent start with L=1, init_i=5 → result=25.

Source files
------------

// File: rtl/dot_prod_stream.sv
// dot_prod_stream: pipelined dot product over two synchronous-read arrays.
// Issue one element per cycle, register the product, then accumulate with
// optional saturation. A start strobe aborts any run in flight and restarts.
module dot_prod_stream #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W:0]   init_len,
  input  logic [ACC_W-1:0]  init_acc,
  input  logic              mode_signed,
  input  logic              mode_sat,
  output logic              arrRen,
  output logic [ADDR_W-1:0] arrRaddr_a,
  output logic [ADDR_W-1:0] arrRaddr_b,
  input  logic [DATA_W-1:0] arrRdata_a,
  input  logic [DATA_W-1:0] arrRdata_b,
  output logic              busy,
  output logic              w_enable,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} st_e;

  st_e               st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;      // elements still to issue, including current
  logic [2:0]        vld_q;      // [0] issue, [1] read data, [2] product
  logic [2:0]        lst_q;      // marks the final element in each stage
  logic [PW-1:0]     prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic              sgn_q, sat_q, busy_q, wen_q, ovf_q;
  logic              zl_q;       // zero-length start: raise w_enable next cycle

  logic [PW-1:0]     a_x, b_x, prod_d;
  logic [ACC_W-1:0]  pext, acc_d;
  logic [ACC_W:0]    sum;
  logic              ovf_d;
  logic [ADDR_W-1:0] addr_nx;

  // Operand extension, multiply, and overflow-aware accumulate.
  always_comb begin
    if (sgn_q) begin
      a_x  = PW'($signed(arrRdata_a));
      b_x  = PW'($signed(arrRdata_b));
      pext = ACC_W'($signed(prod_q));
    end else begin
      a_x  = PW'(arrRdata_a);
      b_x  = PW'(arrRdata_b);
      pext = ACC_W'(prod_q);
    end
    // Low PW bits of the extended product are correct for both signednesses.
    prod_d = a_x * b_x;
    sum    = {1'b0, acc_q} + {1'b0, pext};
    if (sgn_q)
      ovf_d = (acc_q[ACC_W-1] == pext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf_d = sum[ACC_W];
    acc_d = sum[ACC_W-1:0];
    // Signed overflow only happens with equal signs, so acc sign picks the rail.
    if (ovf_d && sat_q) begin
      if (!sgn_q)              acc_d = '1;
      else if (acc_q[ACC_W-1]) acc_d = {1'b1, {(ACC_W-1){1'b0}}};
      else                     acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Wrapping index increment.
  always_comb begin
    addr_nx = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  end

  // Control FSM, pipeline valid chain and accumulator; start overrides all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      lst_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      sgn_q  <= 1'b0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      wen_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zl_q   <= 1'b0;
    end else begin
      vld_q[2:1] <= vld_q[1:0];
      lst_q[2:1] <= lst_q[1:0];
      if (vld_q[1]) prod_q <= prod_d;
      if (vld_q[2]) begin
        acc_q <= acc_d;
        if (ovf_d) ovf_q <= 1'b1;
        if (lst_q[2]) begin
          wen_q  <= 1'b1;
          busy_q <= 1'b0;
          st_q   <= DONE;
        end
      end
      if (zl_q) begin
        wen_q <= 1'b1;
        zl_q  <= 1'b0;
      end
      if (st_q == ISSUE) begin
        if (cnt_q == (ADDR_W+1)'(1)) begin
          vld_q[0] <= 1'b0;
          lst_q[0] <= 1'b0;
          st_q     <= DRAIN;
        end else begin
          addr_q   <= addr_nx;
          cnt_q    <= cnt_q - 1'b1;
          lst_q[0] <= (cnt_q == (ADDR_W+1)'(2));
        end
      end
      if (r_enable) begin
        vld_q[2:1] <= '0;
        lst_q[2:1] <= '0;
        acc_q      <= init_acc;
        ovf_q      <= 1'b0;
        wen_q      <= 1'b0;
        sgn_q      <= mode_signed;
        sat_q      <= mode_sat;
        addr_q     <= init_i;
        cnt_q      <= init_len;
        if (init_len == '0) begin
          st_q     <= DONE;
          zl_q     <= 1'b1;
          busy_q   <= 1'b0;
          vld_q[0] <= 1'b0;
          lst_q[0] <= 1'b0;
        end else begin
          st_q     <= ISSUE;
          zl_q     <= 1'b0;
          busy_q   <= 1'b1;
          vld_q[0] <= 1'b1;
          lst_q[0] <= (init_len == (ADDR_W+1)'(1));
        end
      end
    end
  end

  assign arrRen     = vld_q[0];
  assign arrRaddr_a = addr_q;
  assign arrRaddr_b = addr_q;
  assign busy       = busy_q;
  assign w_enable   = wen_q;
  assign result     = acc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_dot_prod_stream.sv
// Directed bench for dot_prod_stream with a synchronous-read array model.
module tb_dot_prod_stream;
  localparam int DW = 32, AW = 64, DEPTH = 1000, ADW = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           r_enable;
  logic [ADW-1:0] init_i;
  logic [ADW:0]   init_len;
  logic [AW-1:0]  init_acc;
  logic           mode_signed, mode_sat;
  logic           arrRen;
  logic [ADW-1:0] arrRaddr_a, arrRaddr_b;
  logic [DW-1:0]  arrRdata_a, arrRdata_b;
  logic           busy, w_enable, overflow;
  logic [AW-1:0]  result;

  logic [DW-1:0]  mem [DEPTH];

  dot_prod_stream #(.DATA_W(DW), .ACC_W(AW), .DEPTH(DEPTH), .ADDR_W(ADW)) dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_i(init_i),
    .init_len(init_len), .init_acc(init_acc), .mode_signed(mode_signed),
    .mode_sat(mode_sat), .arrRen(arrRen), .arrRaddr_a(arrRaddr_a),
    .arrRaddr_b(arrRaddr_b), .arrRdata_a(arrRdata_a), .arrRdata_b(arrRdata_b),
    .busy(busy), .w_enable(w_enable), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // synchronous-read arrays (a and b share contents)
  always @(posedge clk) begin
    if (arrRen) begin
      arrRdata_a <= mem[arrRaddr_a];
      arrRdata_b <= mem[arrRaddr_b];
    end
  end

  int nchk = 0, nerr = 0;
  int lat, nren, nbusy, addr_err;
  logic [ADW-1:0] alog [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse r_enable across one rising edge (E0); returns at the negedge after E0.
  task automatic start(input logic [ADW-1:0] i, input logic [ADW:0] len,
                       input logic [AW-1:0] acc, input logic sat);
    @(negedge clk);
    init_i = i; init_len = len; init_acc = acc;
    mode_signed = 1'b1; mode_sat = sat; r_enable = 1'b1;
    @(negedge clk);
    r_enable = 1'b0;
  endtask

  // Wait (bounded) for w_enable; lat = edges after E0 when it was first seen.
  task automatic run_wait(input int lim);
    lat = 0; nren = 0; nbusy = 0; addr_err = 0;
    while (!w_enable && lat < lim) begin
      if (arrRen) begin
        if (nren < 8) alog[nren] = arrRaddr_a;
        if (arrRaddr_a !== arrRaddr_b) addr_err++;
        nren++;
      end
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("w_enable_seen", {63'b0, w_enable}, 64'd1);
  endtask

  task automatic fill_idx();
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
  endtask

  initial begin
    rst = 1'b1; r_enable = 1'b0; init_i = '0; init_len = '0; init_acc = '0;
    mode_signed = 1'b1; mode_sat = 1'b0;
    fill_idx();
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_wen", {63'b0, w_enable}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_ovf", {63'b0, overflow}, 64'd0);
    chk("rst_ren", {63'b0, arrRen}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: full run
    start(10'd0, 11'd1000, 64'd0, 1'b0);
    run_wait(1100);
    chk("full_lat", 64'(lat), 64'd1002);
    chk("full_ren_cycles", 64'(nren), 64'd1000);
    chk("full_busy_cycles", 64'(nbusy), 64'd1002);
    chk("full_addr_eq", 64'(addr_err), 64'd0);
    chk("full_result", result, 64'd332833500);
    chk("full_ovf", {63'b0, overflow}, 64'd0);
    repeat (3) @(negedge clk);
    chk("full_wen_held", {63'b0, w_enable}, 64'd1);
    chk("full_busy_low", {63'b0, busy}, 64'd0);

    // 2: index wrap
    start(10'd998, 11'd4, 64'd6, 1'b0);
    run_wait(50);
    chk("wrap_addr0", 64'(alog[0]), 64'd998);
    chk("wrap_addr1", 64'(alog[1]), 64'd999);
    chk("wrap_addr2", 64'(alog[2]), 64'd0);
    chk("wrap_addr3", 64'(alog[3]), 64'd1);
    chk("wrap_result", result, 64'd1994012);
    chk("wrap_lat", 64'(lat), 64'd6);

    // 3: zero length
    start(10'd0, 11'd0, 64'd42, 1'b0);
    run_wait(10);
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_ren", 64'(nren), 64'd0);
    chk("zero_busy", 64'(nbusy), 64'd0);
    chk("zero_result", result, 64'd42);

    // 4: saturation vs wrap
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'h8000_0000;
    start(10'd0, 11'd2, 64'h4000_0000_0000_0000, 1'b1);
    run_wait(20);
    chk("sat_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sat_ovf", {63'b0, overflow}, 64'd1);
    start(10'd0, 11'd2, 64'h4000_0000_0000_0000, 1'b0);
    run_wait(20);
    chk("wrapmode_result", result, 64'hC000_0000_0000_0000);
    chk("wrapmode_ovf", {63'b0, overflow}, 64'd1);

    // 5: abort mid-run
    fill_idx();
    start(10'd0, 11'd1000, 64'd0, 1'b0);
    chk("start_clr_wen", {63'b0, w_enable}, 64'd0);
    chk("start_clr_ovf", {63'b0, overflow}, 64'd0);
    repeat (9) @(negedge clk);
    start(10'd2, 11'd3, 64'd0, 1'b0);
    run_wait(50);
    chk("abort_lat", 64'(lat), 64'd5);
    chk("abort_result", result, 64'd29);
    chk("abort_ovf", {63'b0, overflow}, 64'd0);

    // 6: asynchronous reset mid-run
    start(10'd0, 11'd1000, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_wen", {63'b0, w_enable}, 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_ren", {63'b0, arrRen}, 64'd0);
    chk("arst_addr", 64'(arrRaddr_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    start(10'd5, 11'd1, 64'd0, 1'b0);
    run_wait(20);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_result", result, 64'd25);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
